// File: rtl/slave_port_pkg.sv
// Shared types and default parameter constants for the slave_port_v3 serial slave.
// Optional burst support is compiled in with SLAVE_PORT_V3_BURST_EN.
package slave_port_pkg;

    localparam int unsigned AddrWidthDef  = 16;
    localparam int unsigned DataWidthDef  = 8;
    localparam int unsigned MemDepthDef   = 64;
    localparam int unsigned BurstWidthDef = 4;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
`ifdef SLAVE_PORT_V3_BURST_EN
        StLen,
`endif
        StData,
        StWrite,
        StRead,
        StSend
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/slave_port_ram.sv
// Backing store for slave_port_v3: synchronous write, registered read.
module slave_port_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 64,
    parameter int unsigned IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_WIDTH-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_WIDTH-1:0]  raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset: contents must survive a port reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slave_port_v3.sv
// Bit-serial memory slave: address/length/data shifted in MSB first, reads shifted out.
// Define SLAVE_PORT_V3_BURST_EN to add the LEN header field and multi-beat bursts.
module slave_port_v3
    import slave_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = AddrWidthDef,
    parameter int unsigned DATA_WIDTH  = DataWidthDef,
    parameter int unsigned MEM_DEPTH   = MemDepthDef,
    parameter int unsigned BURST_WIDTH = BurstWidthDef
) (
    input  logic clk,
    input  logic rst,
    input  logic mode,
    input  logic wr_bus,
    input  logic master_valid,
    input  logic master_ready,
    output logic rd_bus,
    output logic slave_ready,
    output logic slave_valid,
    output logic frame_err
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
`ifdef SLAVE_PORT_V3_BURST_EN
    localparam int unsigned MaxW = max3(ADDR_WIDTH, DATA_WIDTH, BURST_WIDTH);
`else
    localparam int unsigned MaxW = max3(ADDR_WIDTH, DATA_WIDTH, 1);
`endif
    localparam int unsigned CntW = $clog2(MaxW + 1);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  err_q, err_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] sin_q, sin_d;
    logic [DATA_WIDTH-1:0] sout_q, sout_d;
    logic                  last_beat;

    logic                  ram_we, ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef SLAVE_PORT_V3_BURST_EN
    logic [BURST_WIDTH-1:0] len_q, len_d;
    logic [BURST_WIDTH-1:0] beat_q, beat_d;

    assign last_beat = (beat_q == len_q);
`else
    logic unused_burst;

    assign unused_burst = ^BURST_WIDTH;
    assign last_beat    = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            sin_q   <= '0;
            sout_q  <= '0;
`ifdef SLAVE_PORT_V3_BURST_EN
            len_q   <= '0;
            beat_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sin_q   <= sin_d;
            sout_q  <= sout_d;
`ifdef SLAVE_PORT_V3_BURST_EN
            len_q   <= len_d;
            beat_q  <= beat_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        sin_d       = sin_q;
        sout_d      = sout_q;
`ifdef SLAVE_PORT_V3_BURST_EN
        len_d       = len_q;
        beat_d      = beat_q;
`endif
        ram_we      = 1'b0;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rd_bus      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                addr_d = '0;
                sin_d  = '0;
                sout_d = '0;
`ifdef SLAVE_PORT_V3_BURST_EN
                len_d  = '0;
                beat_d = '0;
`endif
                if (master_valid) begin
                    mode_d  = mode;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                slave_ready = 1'b1;
                if (!master_valid) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    addr_d = ADDR_WIDTH'({addr_q, wr_bus});
                    if (cnt_q == CntW'(ADDR_WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef SLAVE_PORT_V3_BURST_EN
                        state_d = StLen;
`else
                        state_d = mode_q ? StData : StRead;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SLAVE_PORT_V3_BURST_EN
            StLen: begin
                slave_ready = 1'b1;
                if (!master_valid) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    len_d = BURST_WIDTH'({len_q, wr_bus});
                    if (cnt_q == CntW'(BURST_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = mode_q ? StData : StRead;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            StData: begin
                slave_ready = 1'b1;
                if (!master_valid) begin
                    // Abort drops the partial beat; earlier beats are already in memory.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    sin_d = DATA_WIDTH'({sin_q, wr_bus});
                    if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                ram_we = 1'b1;
                sin_d  = '0;
                if (last_beat) begin
                    state_d = StIdle;
                end else begin
                    addr_d  = addr_q + 1'b1;
`ifdef SLAVE_PORT_V3_BURST_EN
                    beat_d  = beat_q + 1'b1;
`endif
                    state_d = StData;
                end
            end
            StRead: begin
                sout_d  = ram_rdata;
                cnt_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                slave_valid = 1'b1;
                rd_bus      = sout_q[DATA_WIDTH-1];
                if (master_ready) begin
                    sout_d = sout_q << 1;
                    if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        cnt_d = '0;
                        if (last_beat) begin
                            state_d = StIdle;
                        end else begin
                            addr_d  = addr_q + 1'b1;
`ifdef SLAVE_PORT_V3_BURST_EN
                            beat_d  = beat_q + 1'b1;
`endif
                            state_d = StRead;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The RAM registers its output on the edge entering READ, so look up the next address.
    assign ram_re    = (state_d == StRead);
    assign frame_err = err_q;

    slave_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_WIDTH  (IdxW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (addr_q[IdxW-1:0]),
        .wdata_i (sin_q),
        .re_i    (ram_re),
        .raddr_i (addr_d[IdxW-1:0]),
        .rdata_o (ram_rdata)
    );

endmodule

// File: doc/slave_port_v3.md
SLAVE_PORT_V3 -- requirements
Module: slave_port_v3

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, serial address field width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, data beat width in bits.
REQ-003 Parameter MEM_DEPTH, default 64, backing memory word count; SHALL be a power of two, 2 to 2**ADDR_WIDTH.
REQ-004 Parameter BURST_WIDTH, default 4, burst length field width in bits (used only with burst enabled).
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 mode  input  1  1 = write frame, 0 = read frame.
REQ-008 wr_bus  input  1  serial data from master, MSB first.
REQ-009 master_valid  input  1  master drives a valid bit on wr_bus.
REQ-010 master_ready  input  1  master accepts the current rd_bus bit.
REQ-011 rd_bus  output  1  serial read data to master, MSB first.
REQ-012 slave_ready  output  1  slave accepts a wr_bus bit this cycle.
REQ-013 slave_valid  output  1  rd_bus holds a valid bit.
REQ-014 frame_err  output  1  one-cycle pulse on an aborted frame.

Function
REQ-015 States: IDLE, ADDR, LEN, DATA, WRITE, READ, SEND.
REQ-016 IDLE: slave_ready=0, slave_valid=0; master_valid=1 -> ADDR; mode is captured on this transition and held for the whole frame.
REQ-017 ADDR, LEN and DATA assert slave_ready=1; a bit is shifted in only on a cycle where slave_ready and master_valid are both 1.
REQ-018 ADDR shifts ADDR_WIDTH bits; after the last bit -> LEN (burst enabled), else -> DATA if writing, else -> READ.
REQ-019 LEN shifts BURST_WIDTH bits, L; beat count = L+1 (1..2**BURST_WIDTH); after the last bit -> DATA if writing, else -> READ.
REQ-020 DATA shifts DATA_WIDTH bits; after the last bit -> WRITE.
REQ-021 WRITE (one cycle): stores the beat at mem[addr mod MEM_DEPTH]; -> IDLE if this was the last beat, else address +1 and -> DATA.
REQ-022 READ (one cycle): loads mem[addr mod MEM_DEPTH] into the output shifter; -> SEND.
REQ-023 SEND: slave_valid=1, rd_bus=current bit; the shifter advances only when master_ready=1; SEND holds indefinitely while master_ready=0.
REQ-024 Last bit of a SEND beat accepted: -> IDLE if last beat, else address +1 and -> READ.
REQ-025 Read latency: last header bit accepted at cycle N; READ at N+1; SEND with the MSB on rd_bus at N+2.
REQ-026 Address increment wraps modulo MEM_DEPTH; address bits above log2(MEM_DEPTH) are ignored.
REQ-027 master_valid=0 in ADDR, LEN or DATA: -> IDLE, frame_err=1 for one cycle; a partial beat is never written; beats already written are kept.
REQ-028 Outside SEND, rd_bus=0; IDLE clears the counters and shift registers.

Reset
REQ-029 rst=1 immediately forces state IDLE and rd_bus, slave_ready, slave_valid, frame_err = 0, regardless of clk.
REQ-030 Reset mid-frame abandons the frame without frame_err; memory contents are not cleared.

Configuration
REQ-031 Macro SLAVE_PORT_V3_BURST_EN defined: the LEN state and burst field exist per REQ-019.
REQ-032 Macro SLAVE_PORT_V3_BURST_EN undefined: no LEN state, beat count is fixed at 1, ADDR goes straight to DATA or READ, and BURST_WIDTH is unused.

Structure
REQ-033 Package slave_port_pkg SHALL hold the state enum type and the default parameter constants.
REQ-034 Sub-module slave_port_ram: synchronous-write, registered-read memory of MEM_DEPTH x DATA_WIDTH words.

Verification
REQ-035 Write frame, burst off, addr 0x0005, data 0xA5 -> one cycle after the last bit, mem[5]=0xA5; IDLE the next cycle.
REQ-036 Read frame, addr 0x0005, master_ready=1 -> slave_valid high two cycles after the last address bit; rd_bus = 1,0,1,0,0,1,0,1.
REQ-037 Burst on: write L=2 at addr 0x003F, data 0x11,0x22,0x33 -> mem[63]=0x11, mem[0]=0x22, mem[1]=0x33 (wrap-around).
REQ-038 master_valid dropped after 3 of 8 data bits -> frame_err pulses once, state returns to IDLE, target word unchanged.
REQ-039 master_ready held low for 5 cycles mid-SEND -> rd_bus and slave_valid stable, no bit skipped; the read completes normally afterwards.
REQ-040 rst asserted mid-SEND between clock edges -> outputs 0 immediately; after release a new read frame works correctly.
